// File: rtl/lsu_split_pkg.sv
// Shared types and helpers for the load/store splitter and its data-memory port.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package lsu_split_pkg;

    localparam int DefaultAddrWidth = 32;

    // Access width understood by the data memory
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;

    // Splitter FSM state encoding
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t IDLE   = 2'd0;
    localparam lsu_state_t ACCESS = 2'd1;
    localparam lsu_state_t RESP   = 2'd2;

    // Natural alignment: BYTE always, HALF on even addresses, WORD on multiples of 4
    function automatic logic is_aligned(input mem_width_t width, input logic [1:0] addr_lo);
        case (width)
            HALF:    is_aligned = ~addr_lo[0];
            WORD:    is_aligned = (addr_lo == 2'b00);
            default: is_aligned = 1'b1;
        endcase
    endfunction

    // Number of memory beats: one native beat when aligned, otherwise one per byte
    function automatic logic [2:0] beat_count(input mem_width_t width, input logic aligned);
        if (aligned) begin
            beat_count = 3'd1;
        end else if (width == HALF) begin
            beat_count = 3'd2;
        end else begin
            beat_count = 3'd4;
        end
    endfunction

endpackage

// File: rtl/lsu_split.sv
// Load/store unit in front of the data memory; splits misaligned HALF/WORD into byte beats.
// Latency: accept-to-rsp_valid 2 (aligned), 3 (split HALF), 5 (split WORD), 1 (rejected).
// Backpressure: req_ready only in IDLE; one transaction in flight, no response stall.
module lsu_split
    import lsu_split_pkg::*;
#(
    parameter int AddrWidth       = DefaultAddrWidth,
    parameter bit SplitMisaligned = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  mem_width_t           req_width,
    input  logic                 req_sign_extend,
    input  logic [AddrWidth-1:0] req_address,
    input  logic [31:0]          req_data,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 rsp_error,
    output logic                 mem_write_enable,
    output mem_width_t           mem_width,
    output logic                 mem_sign_extend,
    output logic [AddrWidth-1:0] mem_address,
    output logic [31:0]          mem_data_in,
    input  logic [31:0]          mem_data_out,
    input  logic                 mem_alignment_error
);

    lsu_state_t           state;
    logic [1:0]           beat;
    logic                 req_write_q;
    mem_width_t           req_width_q;
    logic                 req_sign_q;
    logic [AddrWidth-1:0] req_addr_q;
    logic [31:0]          req_data_q;
    logic                 aligned_q;
    logic [31:0]          data_acc;
    logic [31:0]          final_data;
    logic [2:0]           n_beats;
    logic                 accept;
    logic                 req_aligned;
    logic                 last_beat;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign req_aligned = is_aligned(req_width, req_address[1:0]);
    assign n_beats     = beat_count(req_width_q, aligned_q);
    assign last_beat   = ({1'b0, beat} == (n_beats - 3'd1));

    // Final load value: split HALF loads are extended here, aligned loads come pre-extended from mem
    always_comb begin
        final_data = data_acc;
        if (req_write_q) begin
            final_data = 32'h0;
        end else if (!aligned_q && (req_width_q == HALF)) begin
            final_data = {{16{req_sign_q & data_acc[15]}}, data_acc[15:0]};
        end
    end

    // Memory port: idle values outside ACCESS, native beat when aligned, byte beat k otherwise
    always_comb begin
        mem_write_enable = 1'b0;
        mem_width        = WORD;
        mem_sign_extend  = 1'b0;
        mem_address      = '0;
        mem_data_in      = 32'h0;
        if (state == ACCESS) begin
            mem_write_enable = req_write_q;
            if (aligned_q) begin
                mem_width       = req_width_q;
                mem_sign_extend = req_sign_q;
                mem_address     = req_addr_q;
                mem_data_in     = req_data_q;
            end else begin
                mem_width   = BYTE;
                mem_address = req_addr_q + AddrWidth'(beat);
                mem_data_in = {24'h0, req_data_q[{beat, 3'b000} +: 8]};
            end
        end
    end

    // FSM, request capture, beat counter, byte-lane assembly and response pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            beat        <= 2'd0;
            req_write_q <= 1'b0;
            req_width_q <= BYTE;
            req_sign_q  <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= 32'h0;
            aligned_q   <= 1'b0;
            data_acc    <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'h0;
            rsp_error   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_write_q <= req_write;
                        req_width_q <= req_width;
                        req_sign_q  <= req_sign_extend;
                        req_addr_q  <= req_address;
                        req_data_q  <= req_data;
                        aligned_q   <= req_aligned;
                        beat        <= 2'd0;
                        data_acc    <= 32'h0;
                        if (!req_aligned && !SplitMisaligned) begin
                            // Rejected: skip memory entirely and report the error
                            rsp_error <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rsp_error <= 1'b0;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    rsp_error <= rsp_error | mem_alignment_error;
                    if (!req_write_q) begin
                        if (aligned_q) begin
                            data_acc <= mem_data_out;
                        end else begin
                            data_acc[{beat, 3'b000} +: 8] <= mem_data_out[7:0];
                        end
                    end
                    beat <= beat + 2'd1;
                    if (last_beat) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= final_data;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
